instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter PC_RESET, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ireq_valid  output  1  instruction-bus request valid.
REQ-005 ireq_addr  output  64  instruction-bus request address.
REQ-006 iresp_addr_ok  input  1  bus accepted the current request.
REQ-007 iresp_data_ok  input  1  instruction data returned this cycle.
REQ-008 iresp_data  input  32  returned instruction word.
REQ-009 stall  input  1  decode cannot accept the held instruction this cycle.
REQ-010 redirect_valid  input  1  branch/jump resolved taken; refetch from redirect_pc.
REQ-011 redirect_pc  input  64  redirect target.
REQ-012 out_valid  output  1  fetch_data_t.valid to decode.
REQ-013 out_instr  output  32  fetch_data_t.instr.
REQ-014 out_pc  output  64  fetch_data_t.pc.

Function
REQ-015 The block SHALL hold a pc register, an output register (out_valid/out_instr/out_pc), a squash flag with a 64-bit target register, and an FSM with states REQ, WAIT and HOLD.
REQ-016 In REQ the block SHALL drive ireq_valid=1 and ireq_addr=pc; in WAIT and HOLD it SHALL drive ireq_valid=0.
REQ-017 Once ireq_valid is asserted, ireq_addr SHALL stay constant until a cycle with iresp_addr_ok=1, even if redirect_valid arrives.
REQ-018 REQ with addr_ok=1 and data_ok=0 SHALL go to WAIT; REQ with addr_ok=1 and data_ok=1 in the same cycle SHALL be treated as a completed fetch.
REQ-019 A completed, unsquashed fetch SHALL load out_valid=1, out_instr=iresp_data and out_pc=pc, set pc=pc+4 (mod 2^64, wrap-around), and enter HOLD, so out_valid rises the cycle after data_ok.
REQ-020 out_valid SHALL be 1 only in HOLD; in HOLD with stall=0 and no redirect, the block SHALL clear out_valid and enter REQ (handoff cycle = the HOLD cycle with stall=0).
REQ-021 In HOLD with stall=1, out_valid/out_instr/out_pc SHALL remain unchanged.
REQ-022 Redirect in HOLD SHALL clear out_valid, set pc=redirect_pc and enter REQ, regardless of stall.
REQ-023 Redirect in REQ or WAIT (the request already presented or accepted) SHALL set squash=1 and target=redirect_pc; a later redirect before the squash resolves SHALL overwrite target (latest wins).
REQ-024 A fetch that completes while squash=1, or in the same cycle as redirect_valid, SHALL be discarded (out_valid stays 0), pc SHALL be set to the target (or redirect_pc if redirect is in that cycle), squash cleared, next state REQ.
REQ-025 While squash=1 in REQ, the block SHALL keep presenting the stale address until addr_ok, then follow the REQ/WAIT rules and discard the data.
REQ-026 At most one bus transaction SHALL be outstanding; a new request SHALL not be issued while in WAIT or HOLD.
REQ-027 redirect_pc SHALL be used unmodified, without alignment checks.

Reset
REQ-028 While reset=1 at a clock edge: state=REQ, pc=PC_RESET, out_valid=0, out_instr=0, out_pc=0, squash=0, target=0.
REQ-029 The cycle after reset deasserts, ireq_valid=1 and ireq_addr=PC_RESET.
REQ-030 Reset mid-transaction SHALL abandon the outstanding fetch; the bus is reset concurrently and delivers no stale data_ok.

Verification
REQ-031 Reset, then addr_ok and data_ok together with data 32'h0000_0013 -> next cycle out_valid=1, out_pc=64'h8000_0000, out_instr=32'h13; after handoff ireq_addr=64'h8000_0004.
REQ-032 addr_ok in cycle 1, data_ok in cycle 4 -> ireq_valid=0 during cycles 2-4, out_valid=1 in cycle 5 only.
REQ-033 Hold stall=1 for 3 cycles in HOLD -> output stable for 3 cycles, no new request; stall=0 -> REQ next cycle with pc+4.
REQ-034 Redirect to 64'h8000_0100 while in WAIT, then data_ok -> data dropped, out_valid stays 0, next ireq_addr=64'h8000_0100.
REQ-035 Redirect in REQ with addr_ok=0 for 2 cycles -> ireq_addr stays the old pc until addr_ok; that response is discarded; the next request goes to the redirect target.
REQ-036 pc=64'hFFFF_FFFF_FFFF_FFFC fetch completes -> out_pc=64'hFFFF_FFFF_FFFF_FFFC, next ireq_addr=64'h0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one bus request at a time, holds the returned
// instruction for decode, and squashes in-flight fetches on redirect.
module instr_fetch #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic        squash_q, squash_d;
  logic [63:0] target_q, target_d;

  // A fetch finishes on data_ok, either directly in REQ (with addr_ok) or in WAIT.
  logic fetch_done;
  logic discard;

  always_comb begin
    fetch_done = ((state_q == StReq) && iresp_addr_ok && iresp_data_ok) ||
                 ((state_q == StWait) && iresp_data_ok);
    discard    = squash_q || redirect_valid;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    squash_d    = squash_q;
    target_d    = target_q;

    unique case (state_q)
      StReq, StWait: begin
        if (fetch_done) begin
          if (discard) begin
            pc_d     = redirect_valid ? redirect_pc : target_q;
            squash_d = 1'b0;
            state_d  = StReq;
          end else begin
            out_valid_d = 1'b1;
            out_instr_d = iresp_data;
            out_pc_d    = pc_q;
            pc_d        = pc_q + 64'd4;
            state_d     = StHold;
          end
        end else begin
          // Request is already on the bus; remember the redirect until it drains.
          if (redirect_valid) begin
            squash_d = 1'b1;
            target_d = redirect_pc;
          end
          if ((state_q == StReq) && iresp_addr_ok) begin
            state_d = StWait;
          end
        end
      end
      StHold: begin
        if (redirect_valid) begin
          out_valid_d = 1'b0;
          pc_d        = redirect_pc;
          state_d     = StReq;
        end else if (!stall) begin
          out_valid_d = 1'b0;
          state_d     = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StReq;
      pc_q        <= PC_RESET;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_pc_q    <= 64'd0;
      squash_q    <= 1'b0;
      target_q    <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      squash_q    <= squash_d;
      target_q    <= target_d;
    end
  end

  always_comb begin
    ireq_valid = (state_q == StReq);
    ireq_addr  = pc_q;
    out_valid  = out_valid_q;
    out_instr  = out_instr_q;
    out_pc     = out_pc_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; expected decode outputs are queued when bus data
// is driven and popped when the stage presents them.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  instr_fetch #(
    .PC_RESET(64'h0000_0000_8000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [63:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic expect_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_instr"}, {32'd0, out_instr}, {32'd0, e.instr});
      chk({tag, "_pc"}, out_pc, e.pc);
    end
  endtask

  task automatic clear_bus();
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'd0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_pc = 64'd0;
    clear_bus();
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);

    // Same-cycle addr_ok/data_ok
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
    push_exp(32'h0000_0013, 64'h8000_0000);
    step();
    clear_bus();
    expect_out("fast");
    chk("fast_hold_noreq", {63'd0, ireq_valid}, 64'd0);
    step();
    chk("fast_handoff_valid", {63'd0, out_valid}, 64'd0);
    chk("fast_next_req", {63'd0, ireq_valid}, 64'd1);
    chk("fast_next_addr", ireq_addr, 64'h8000_0004);

    // addr_ok in cycle 1, data_ok in cycle 4
    iresp_addr_ok = 1'b1;
    step();
    clear_bus();
    chk("wait_c2_req", {63'd0, ireq_valid}, 64'd0);
    step();
    chk("wait_c3_req", {63'd0, ireq_valid}, 64'd0);
    step();
    chk("wait_c4_req", {63'd0, ireq_valid}, 64'd0);
    chk("wait_c4_out", {63'd0, out_valid}, 64'd0);
    iresp_data_ok = 1'b1; iresp_data = 32'h00a0_0093;
    push_exp(32'h00a0_0093, 64'h8000_0004);
    step();
    clear_bus();
    expect_out("wait_c5");
    step();
    chk("wait_c6_out", {63'd0, out_valid}, 64'd0);
    chk("wait_c6_addr", ireq_addr, 64'h8000_0008);

    // Stall in HOLD for 3 cycles
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0010_8113;
    push_exp(32'h0010_8113, 64'h8000_0008);
    step();
    clear_bus();
    expect_out("stall_first");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_instr", {32'd0, out_instr}, 64'h0010_8113);
      chk("stall_pc", out_pc, 64'h8000_0008);
      chk("stall_noreq", {63'd0, ireq_valid}, 64'd0);
    end
    stall = 1'b0;
    step();
    chk("unstall_valid", {63'd0, out_valid}, 64'd0);
    chk("unstall_req", {63'd0, ireq_valid}, 64'd1);
    chk("unstall_addr", ireq_addr, 64'h8000_000C);

    // Redirect while in WAIT; returning data is dropped
    iresp_addr_ok = 1'b1;
    step();
    clear_bus();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    step();
    clear_bus();
    iresp_data_ok = 1'b1; iresp_data = 32'hdead_beef;
    step();
    clear_bus();
    chk("wredir_dropped", {63'd0, out_valid}, 64'd0);
    chk("wredir_req", {63'd0, ireq_valid}, 64'd1);
    chk("wredir_addr", ireq_addr, 64'h8000_0100);

    // Redirect in REQ with addr_ok low for 2 cycles; latest target wins
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0180;
    step();
    chk("rredir_hold_addr1", ireq_addr, 64'h8000_0100);
    chk("rredir_hold_valid1", {63'd0, ireq_valid}, 64'd1);
    redirect_pc = 64'h8000_0200;
    step();
    clear_bus();
    chk("rredir_hold_addr2", ireq_addr, 64'h8000_0100);
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'hbad0_0bad;
    step();
    clear_bus();
    chk("rredir_dropped", {63'd0, out_valid}, 64'd0);
    chk("rredir_addr", ireq_addr, 64'h8000_0200);

    // Redirect in HOLD despite stall, to the top of the address space
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0000_0073;
    push_exp(32'h0000_0073, 64'h8000_0200);
    step();
    clear_bus();
    expect_out("hredir_first");
    stall = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    clear_bus();
    stall = 1'b0;
    chk("hredir_valid", {63'd0, out_valid}, 64'd0);
    chk("hredir_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // pc wrap-around
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0000_006f;
    push_exp(32'h0000_006f, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    clear_bus();
    expect_out("wrap");
    step();
    chk("wrap_addr", ireq_addr, 64'h0);

    // Reset mid-transaction
    iresp_addr_ok = 1'b1;
    step();
    clear_bus();
    chk("mid_wait", {63'd0, ireq_valid}, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_req", {63'd0, ireq_valid}, 64'd1);
    chk("mid_rst_addr", ireq_addr, 64'h8000_0000);
    chk("mid_rst_out", {63'd0, out_valid}, 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
